// File: rtl/display_pkg.sv
// Shared display-pipeline types: sequencer FSM states and brightness constants.
package display_pkg;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    localparam logic [3:0] BRIGHT_MAX        = 4'd15;
    localparam logic [3:0] BRIGHT_FADE_START = 4'd14;
    localparam logic [3:0] BRIGHT_FADE_IN    = 4'd1;

    function automatic logic [3:0] bright_step(input logic [3:0] b, input logic up);
        return up ? (b + 4'd1) : (b - 4'd1);
    endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser plus counting debouncer; emits a one-cycle pulse on a
// debounced rising edge.
module debounce #(
    parameter int DB_CYCLES = 2**16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_rise
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_rise;
    logic [CW-1:0] r_cnt;
    logic          w_update;

    // The stable level flips on the DB_CYCLES-th consecutive cycle of disagreement.
    assign w_update = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= w_update && r_sync2;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_update) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer: steps through patterns on button or dwell timeout,
// with a frame-paced fade out / fade in around every pattern change.
module pattern_sequencer
    import display_pkg::*;
#(
    parameter int NUM_PAT          = 4,
    parameter int PATW             = 2,
    parameter int DWELL_FRAMES     = 300,
    parameter int FADE_STEP_FRAMES = 2,
    parameter int DB_CYCLES        = 2**16
) (
    input  logic            clk_pix,
    input  logic            rst_pix,
    input  logic            frame,
    input  logic            btn_next,
    input  logic            auto_en,
    output logic [PATW-1:0] pattern,
    output logic [3:0]      bright,
    output logic            busy,
    output logic            pat_change
);

    localparam int DWW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int SW  = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [DWW-1:0]  DWELL_LAST = DWW'(DWELL_FRAMES - 1);
    localparam logic [SW-1:0]   STEP_LAST  = SW'(FADE_STEP_FRAMES - 1);
    localparam logic [PATW-1:0] PAT_LAST   = PATW'(NUM_PAT - 1);

    generate
        if (NUM_PAT < 1 || NUM_PAT > 2**PATW) begin : g_bad_cfg
            $error("pattern_sequencer: NUM_PAT must be in 1..2**PATW");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DWW-1:0]  r_dwell,      w_dwell_nxt;
    logic [SW-1:0]   r_step,       w_step_nxt;
    logic            r_pending,    w_pending_nxt;
    logic [PATW-1:0] r_pattern,    w_pattern_nxt;
    logic [3:0]      r_bright,     w_bright_nxt;
    logic            r_busy;
    logic            r_pat_change, w_pat_change_nxt;
    logic            w_rise;
    logic            w_dwell_req;
    logic            w_start;
    logic            w_step_frame;

    debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .i_clk   (clk_pix),
        .i_rst_n (rst_pix),
        .i_btn   (btn_next),
        .o_rise  (w_rise)
    );

    // A rising edge on the frame cycle itself counts for that frame.
    assign w_dwell_req  = auto_en && (r_dwell == DWELL_LAST);
    assign w_start      = frame && (r_state == SHOW) && (r_pending || w_rise || w_dwell_req);
    assign w_step_frame = frame && (r_step == STEP_LAST);

    always_ff @(posedge clk_pix) begin
        if (!rst_pix) begin
            r_state <= SHOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SHOW:     if (w_start) w_state_nxt = FADE_OUT;
            FADE_OUT: if (w_step_frame && r_bright == 4'd0) w_state_nxt = FADE_IN;
            FADE_IN:  if (w_step_frame && r_bright == BRIGHT_MAX - 4'd1) w_state_nxt = SHOW;
            default:  w_state_nxt = SHOW;
        endcase
    end

    always_comb begin
        w_dwell_nxt      = r_dwell;
        w_step_nxt       = r_step;
        w_pending_nxt    = r_pending;
        w_pattern_nxt    = r_pattern;
        w_bright_nxt     = r_bright;
        w_pat_change_nxt = 1'b0;
        case (r_state)
            SHOW: begin
                if (frame && auto_en && r_dwell != DWELL_LAST) w_dwell_nxt = r_dwell + 1'b1;
                if (w_rise) w_pending_nxt = 1'b1;
                if (w_start) begin
                    w_pending_nxt = 1'b0;
                    w_bright_nxt  = BRIGHT_FADE_START;
                    w_step_nxt    = '0;
                end
            end
            FADE_OUT: begin
                if (w_step_frame) begin
                    w_step_nxt = '0;
                    if (r_bright != 4'd0) begin
                        w_bright_nxt = bright_step(r_bright, 1'b0);
                    end else begin
                        w_pattern_nxt    = (r_pattern == PAT_LAST) ? '0 : r_pattern + 1'b1;
                        w_bright_nxt     = BRIGHT_FADE_IN;
                        w_pat_change_nxt = 1'b1;
                    end
                end else if (frame) begin
                    w_step_nxt = r_step + 1'b1;
                end
            end
            FADE_IN: begin
                if (w_step_frame) begin
                    w_step_nxt   = '0;
                    w_bright_nxt = bright_step(r_bright, 1'b1);
                    if (r_bright == BRIGHT_MAX - 4'd1) w_dwell_nxt = '0;
                end else if (frame) begin
                    w_step_nxt = r_step + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_pix) begin
            r_dwell      <= '0;
            r_step       <= '0;
            r_pending    <= 1'b0;
            r_pattern    <= '0;
            r_bright     <= BRIGHT_MAX;
            r_busy       <= 1'b0;
            r_pat_change <= 1'b0;
        end else begin
            r_dwell      <= w_dwell_nxt;
            r_step       <= w_step_nxt;
            r_pending    <= w_pending_nxt;
            r_pattern    <= w_pattern_nxt;
            r_bright     <= w_bright_nxt;
            r_busy       <= (w_state_nxt != SHOW);
            r_pat_change <= w_pat_change_nxt;
        end
    end

    assign pattern    = r_pattern;
    assign bright     = r_bright;
    assign busy       = r_busy;
    assign pat_change = r_pat_change;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: frames every 100 cycles, fade step of 1 frame.
module tb_pattern_sequencer;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b0;
    logic       frame = 1'b0;
    logic       btn_next = 1'b0;
    logic       auto_en = 1'b0;
    logic [1:0] pattern;
    logic [3:0] bright;
    logic       busy;
    logic       pat_change;

    int checks = 0;
    int failures = 0;
    int press_left = 0;
    int pc_count = 0;
    logic [1:0] fp_pattern;
    logic [3:0] fp_bright;
    logic       fp_busy;
    logic       fp_pc;
    logic       unstable = 1'b0;

    always #5 clk_pix = ~clk_pix;

    pattern_sequencer #(
        .NUM_PAT          (4),
        .PATW             (2),
        .DWELL_FRAMES     (4),
        .FADE_STEP_FRAMES (1),
        .DB_CYCLES        (4)
    ) dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .frame      (frame),
        .btn_next   (btn_next),
        .auto_en    (auto_en),
        .pattern    (pattern),
        .bright     (bright),
        .busy       (busy),
        .pat_change (pat_change)
    );

    task automatic cycle();
        btn_next = (press_left > 0);
        if (press_left > 0) press_left--;
        @(posedge clk_pix);
        #1;
        if (pat_change === 1'b1) pc_count++;
    endtask

    // One 100-cycle frame; fp_* hold the outputs one cycle after the frame pulse.
    task automatic frame_period(input int press_at, input int press_len);
        for (int c = 0; c < 100; c++) begin
            frame = (c == 0);
            if (c == press_at) press_left = press_len;
            cycle();
            if (c == 0) begin
                fp_pattern = pattern;
                fp_bright  = bright;
                fp_busy    = busy;
                fp_pc      = pat_change;
            end else if (pattern !== fp_pattern || bright !== fp_bright) begin
                unstable = 1'b1;
            end
        end
        frame = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame_period(-1, 0);
    endtask

    task automatic apply_reset();
        rst_pix = 1'b0;
        frame = 1'b0;
        press_left = 0;
        for (int i = 0; i < 3; i++) cycle();
        rst_pix = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        rst_pix = 1'b0;
        frame = 1'b0;
        auto_en = 1'b0;
        press_left = 0;
        for (int i = 0; i < 3; i++) cycle();
        checks++; if (pattern !== 2'd0) begin failures++; $display("FAIL reset_pattern: got %0d expected 0", pattern); end
        checks++; if (bright !== 4'd15) begin failures++; $display("FAIL reset_bright: got %0d expected 15", bright); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (pat_change !== 1'b0) begin failures++; $display("FAIL reset_pat_change: got %0b expected 0", pat_change); end
        rst_pix = 1'b1;
        cycle();
    endtask

    task automatic test_auto();
        int pc0;
        pc0 = pc_count;
        auto_en = 1'b1;
        run_frames(3);
        checks++; if (fp_busy !== 1'b0 || fp_bright !== 4'd15) begin failures++; $display("FAIL auto_before_dwell: got busy=%0b bright=%0d expected busy=0 bright=15", fp_busy, fp_bright); end
        frame_period(-1, 0);
        checks++; if (fp_busy !== 1'b1 || fp_bright !== 4'd14) begin failures++; $display("FAIL auto_fade_start: got busy=%0b bright=%0d expected busy=1 bright=14", fp_busy, fp_bright); end
        run_frames(14);
        checks++; if (fp_pattern !== 2'd0 || fp_bright !== 4'd0 || fp_busy !== 1'b1) begin failures++; $display("FAIL auto_black: got pattern=%0d bright=%0d busy=%0b expected 0 0 1", fp_pattern, fp_bright, fp_busy); end
        frame_period(-1, 0);
        checks++; if (fp_pattern !== 2'd1 || fp_bright !== 4'd1 || fp_pc !== 1'b1) begin failures++; $display("FAIL auto_pattern_change: got pattern=%0d bright=%0d pat_change=%0b expected 1 1 1", fp_pattern, fp_bright, fp_pc); end
        run_frames(13);
        checks++; if (fp_bright !== 4'd14 || fp_busy !== 1'b1) begin failures++; $display("FAIL auto_fade_in: got bright=%0d busy=%0b expected 14 1", fp_bright, fp_busy); end
        frame_period(-1, 0);
        checks++; if (fp_bright !== 4'd15 || fp_busy !== 1'b0 || fp_pattern !== 2'd1) begin failures++; $display("FAIL auto_show: got bright=%0d busy=%0b pattern=%0d expected 15 0 1", fp_bright, fp_busy, fp_pattern); end
        checks++; if (pc_count - pc0 !== 1) begin failures++; $display("FAIL auto_pc_count: got %0d expected 1", pc_count - pc0); end
        auto_en = 1'b0;
    endtask

    task automatic test_button();
        int pc0;
        pc0 = pc_count;
        auto_en = 1'b0;
        frame_period(20, 10);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL button_wait_frame: got busy=%0b expected 0", busy); end
        frame_period(-1, 0);
        checks++; if (fp_busy !== 1'b1 || fp_bright !== 4'd14 || fp_pattern !== 2'd1) begin failures++; $display("FAIL button_start: got busy=%0b bright=%0d pattern=%0d expected 1 14 1", fp_busy, fp_bright, fp_pattern); end
        run_frames(29);
        checks++; if (pattern !== 2'd2 || bright !== 4'd15 || busy !== 1'b0) begin failures++; $display("FAIL button_done: got pattern=%0d bright=%0d busy=%0b expected 2 15 0", pattern, bright, busy); end
        frame_period(20, 2);
        run_frames(3);
        checks++; if (busy !== 1'b0 || pattern !== 2'd2) begin failures++; $display("FAIL button_glitch: got busy=%0b pattern=%0d expected 0 2", busy, pattern); end
        checks++; if (pc_count - pc0 !== 1) begin failures++; $display("FAIL button_pc_count: got %0d expected 1", pc_count - pc0); end
    endtask

    task automatic test_drop_in_fade();
        int pc0;
        pc0 = pc_count;
        frame_period(20, 10);
        frame_period(-1, 0);
        checks++; if (fp_busy !== 1'b1) begin failures++; $display("FAIL drop_start: got busy=%0b expected 1", fp_busy); end
        frame_period(30, 10);
        run_frames(28);
        checks++; if (pattern !== 2'd3 || busy !== 1'b0) begin failures++; $display("FAIL drop_done: got pattern=%0d busy=%0b expected 3 0", pattern, busy); end
        run_frames(3);
        checks++; if (pattern !== 2'd3 || busy !== 1'b0) begin failures++; $display("FAIL drop_no_second: got pattern=%0d busy=%0b expected 3 0", pattern, busy); end
        checks++; if (pc_count - pc0 !== 1) begin failures++; $display("FAIL drop_pc_count: got %0d expected 1", pc_count - pc0); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [4];
        int pc0;
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        auto_en = 1'b0;
        pc0 = pc_count;
        for (int t = 0; t < 4; t++) begin
            frame_period(20, 10);
            frame_period(-1, 0);
            run_frames(29);
            checks++; if (pattern !== exp_seq[t]) begin failures++; $display("FAIL wrap_seq%0d: got %0d expected %0d", t, pattern, exp_seq[t]); end
        end
        checks++; if (pc_count - pc0 !== 4) begin failures++; $display("FAIL wrap_pc_count: got %0d expected 4", pc_count - pc0); end
    endtask

    task automatic test_simultaneous();
        int pc0;
        apply_reset();
        pc0 = pc_count;
        auto_en = 1'b1;
        run_frames(2);
        frame_period(94, 10);
        frame_period(-1, 0);
        checks++; if (fp_busy !== 1'b1 || fp_bright !== 4'd14) begin failures++; $display("FAIL simul_start: got busy=%0b bright=%0d expected 1 14", fp_busy, fp_bright); end
        run_frames(29);
        auto_en = 1'b0;
        checks++; if (pattern !== 2'd1 || busy !== 1'b0) begin failures++; $display("FAIL simul_done: got pattern=%0d busy=%0b expected 1 0", pattern, busy); end
        run_frames(3);
        checks++; if (pattern !== 2'd1 || busy !== 1'b0) begin failures++; $display("FAIL simul_single: got pattern=%0d busy=%0b expected 1 0", pattern, busy); end
        checks++; if (pc_count - pc0 !== 1) begin failures++; $display("FAIL simul_pc_count: got %0d expected 1", pc_count - pc0); end
    endtask

    task automatic test_mid_fade_reset();
        apply_reset();
        auto_en = 1'b0;
        frame_period(20, 10);
        frame_period(-1, 0);
        run_frames(21);
        checks++; if (fp_bright !== 4'd7 || fp_busy !== 1'b1 || fp_pattern !== 2'd1) begin failures++; $display("FAIL midreset_setup: got bright=%0d busy=%0b pattern=%0d expected 7 1 1", fp_bright, fp_busy, fp_pattern); end
        frame = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rst_pix = 1'b0;
        cycle();
        rst_pix = 1'b1;
        checks++; if (pattern !== 2'd0 || bright !== 4'd15 || busy !== 1'b0 || pat_change !== 1'b0) begin failures++; $display("FAIL midreset_values: got pattern=%0d bright=%0d busy=%0b pat_change=%0b expected 0 15 0 0", pattern, bright, busy, pat_change); end
        run_frames(3);
        checks++; if (pattern !== 2'd0 || bright !== 4'd15 || busy !== 1'b0) begin failures++; $display("FAIL midreset_restart: got pattern=%0d bright=%0d busy=%0b expected 0 15 0", pattern, bright, busy); end
    endtask

    task automatic test_between_frames_constant();
        checks++; if (unstable !== 1'b0) begin failures++; $display("FAIL between_frames: got change=%0b expected 0", unstable); end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_button();
        test_drop_in_fade();
        test_wrap();
        test_simultaneous();
        test_mid_fade_reset();
        test_between_frames_constant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
